// File: rtl/mem_bus_master.sv
// mem_bus_master: single-word initiator for the 64-word ROM/RAM chip bus.
// Define MEM_BUS_MASTER_VERIFY_EN to add a readback-and-compare after each write.
module mem_bus_master #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [5:0]  req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [5:0]  mem_addr,
   output logic        mem_CS,
   output logic        mem_OE,
   output logic        mem_RW,
   output logic [15:0] mem_in,
   input  logic [15:0] mem_out
);
   typedef enum logic [2:0] {
      IDLE, SETUP, ACCESS,
`ifdef MEM_BUS_MASTER_VERIFY_EN
      VSETUP, VACCESS,
`endif
      RESP
   } state_t;
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [15:0] wdata_q;
   logic [5:0]  addr_q;
   logic        cs_q, oe_q, rw_q;
   logic [15:0] din_q;
   logic        rsp_valid_q, rsp_err_q;
   logic [15:0] rsp_rdata_q;
   logic        acc_ok_d;
   // ROM is read-only; the two RAM windows accept both directions
   assign acc_ok_d = (req_addr[5:4] == 2'b00 && !req_we) || req_addr[5:3] == 3'b010 || req_addr[5:3] == 3'b101;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         addr_q      <= '0;
         {cs_q, oe_q, rw_q} <= '0;
         din_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         case (state_q)
            IDLE: if (req_valid) begin
               we_q    <= req_we;
               wdata_q <= req_wdata;
               if (acc_ok_d) begin
                  state_q <= SETUP;
                  addr_q  <= req_addr;
                  cs_q    <= 1'b1;
               end else begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
               end
            end
            SETUP: begin
               state_q <= ACCESS;
               cnt_q   <= CNT_INIT;
               oe_q    <= !we_q;
               rw_q    <= we_q;
               din_q   <= we_q ? wdata_q : '0;
            end
            ACCESS: if (cnt_q != 4'd0) begin
               cnt_q <= cnt_q - 4'd1;
            end else if (we_q) begin
`ifdef MEM_BUS_MASTER_VERIFY_EN
               state_q <= VSETUP;
               rw_q    <= 1'b0;
               din_q   <= '0;
`else
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
               {cs_q, oe_q, rw_q} <= '0;
               addr_q      <= '0;
               din_q       <= '0;
`endif
            end else begin
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= mem_out;
               {cs_q, oe_q, rw_q} <= '0;
               addr_q      <= '0;
               din_q       <= '0;
            end
`ifdef MEM_BUS_MASTER_VERIFY_EN
            VSETUP: begin
               state_q <= VACCESS;
               cnt_q   <= CNT_INIT;
               oe_q    <= 1'b1;
            end
            VACCESS: if (cnt_q != 4'd0) begin
               cnt_q <= cnt_q - 4'd1;
            end else begin
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= mem_out;
               rsp_err_q   <= mem_out != wdata_q;
               {cs_q, oe_q, rw_q} <= '0;
               addr_q      <= '0;
            end
`endif
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign req_ready = state_q == IDLE && !rst;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = addr_q;
   assign mem_CS    = cs_q;
   assign mem_OE    = oe_q;
   assign mem_RW    = rw_q;
   assign mem_in    = din_q;
endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Synchronous initiator for the 64-word memory chip bus (ROM 0x00–0x0F, RAM 0x10–0x17, RAM 0x28–0x2F). It accepts single-word read/write requests from a host over a valid/ready handshake, decodes the address map, sequences CS/OE/RW and the write data through setup and access phases, and samples the read data. It returns one response per accepted request. It sits between the CPU-side logic and the memory chip.

## Interface
Parameters:
- WAIT_CYCLES, 1: access-phase length in cycles; legal range 1–15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  host request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  6  word address.
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  16  read data; 0 on write (non-verify) or error.
- rsp_err  out  1  request failed; qualified by rsp_valid.
- mem_addr  out  6  memory address.
- mem_CS  out  1  chip select.
- mem_OE  out  1  output enable (read).
- mem_RW  out  1  1 = write strobe.
- mem_in  out  16  data to memory.
- mem_out  in  16  data from memory.

## Operation
- States: IDLE, SETUP, ACCESS, VSETUP, VACCESS, RESP. VSETUP and VACCESS exist only with the macro.
- IDLE:
  - req_ready = 1 (forced 0 while rst = 1).
  - A request is accepted when req_valid & req_ready at a rising edge; addr, we and wdata are latched.
- Decode on acceptance:
  - Mapped addresses: 0x00–0x0F (ROM, read-only), 0x10–0x17, 0x28–0x2F.
  - Unmapped address, or a write to the ROM range, goes directly to RESP with rsp_err = 1 and rsp_rdata = 0. No bus activity occurs.
- SETUP (1 cycle): mem_addr = latched addr; mem_CS = 1; mem_OE = 0; mem_RW = 0.
- ACCESS (WAIT_CYCLES cycles, 4-bit down-counter):
  - Read: mem_OE = 1. mem_out is captured at the edge that ends the last ACCESS cycle.
  - Write: mem_RW = 1; mem_in = wdata.
- RESP (1 cycle):
  - rsp_valid = 1; mem_CS, mem_OE and mem_RW = 0.
  - Next state is IDLE.
- There is no response backpressure. The host must consume rsp_* in the cycle rsp_valid is high.
- Outside SETUP, ACCESS, VSETUP and VACCESS: mem_CS = mem_OE = mem_RW = 0, mem_addr = 0, mem_in = 0.
- mem_in is 0 whenever mem_RW = 0.

## Timing
- Cycle 0 is the accept edge.
- Read, or write without verify: SETUP in cycle 1, ACCESS in cycles 2..W+1, rsp_valid in cycle W+2. With W = 1, rsp_valid is in cycle 3.
- Error response: rsp_valid in cycle 1.
- req_ready is low from cycle 1 through the RESP cycle. It returns high the cycle after RESP, so the minimum issue interval is W+3 cycles.
- Reset values:
  - req_ready = 0 while rst is high.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - mem_CS = mem_OE = mem_RW = 0, mem_addr = 0, mem_in = 0.
  - State is IDLE and the wait counter is 0.
- Reset mid-transaction: the bus is released at the next edge and no response is issued. A partially strobed write may leave the RAM word undefined.
- The address does not change while mem_CS = 1.
- RW and OE are never high in the same cycle.

## Configuration
- MEM_BUS_MASTER_VERIFY_EN defined: each successful write is followed by a readback.
  - VSETUP (1 cycle): CS = 1, RW = 0, OE = 0.
  - VACCESS (WAIT_CYCLES cycles): OE = 1.
  - mem_out is captured and compared with wdata. rsp_err = 1 on mismatch.
  - rsp_rdata = the readback value.
  - Write response arrives in cycle 2W+3.
- MEM_BUS_MASTER_VERIFY_EN undefined: writes respond in cycle W+2 with rsp_err = 0 and rsp_rdata = 0. No readback states exist.

## Test plan
- Read 0x05, W = 1 -> mem_OE high in cycle 2 only; rsp_valid in cycle 3; rsp_rdata = 0xFFFA; rsp_err = 0.
- Write 0x12 = 0xBEEF, then read 0x12 -> mem_RW high one cycle with mem_in = 0xBEEF; the read returns 0xBEEF.
- Write 0x2A = 0x1234, then read 0x12 and 0x2A -> reads return the previously written 0x12 value and 0x1234; no aliasing.
- Write 0x03, and read 0x20 -> each responds in cycle 1 with rsp_err = 1 and rsp_rdata = 0; mem_CS stays 0.
- W = 3, rst asserted in the second ACCESS cycle of a read -> bus released at the next edge; no rsp_valid; req_ready high one cycle after rst drops.
- With VERIFY_EN, write 0x15 = 0xA5A5 while the bench forces mem_out = 0x0000 during VACCESS -> rsp_valid in cycle 2W+3; rsp_err = 1; rsp_rdata = 0x0000.
